// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR ADC controller.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DECIDE,
        DONE
    } sar_state_e;

    localparam int unsigned SAR_MIN_SETTLE     = 2;
    localparam int unsigned SAR_SETTLE_DEFAULT = 4;

    function automatic int unsigned sar_cnt_width(input int unsigned settle);
        return (settle > 2) ? $clog2(settle) : 1;
    endfunction

    typedef logic [$clog2(SAR_SETTLE_DEFAULT)-1:0] sar_settle_cnt_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller driving the EPOT DAC tile and sampling
// its comparator; results leave over a valid/ready handshake.
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             ready,
    output logic [WIDTH-1:0] dac_code,
    output logic             dac_en,
    input  logic             cmp_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CNT_W = sar_cnt_width(SETTLE_CYCLES);

    typedef logic [CNT_W-1:0] cnt_t;

    if (SETTLE_CYCLES < SAR_MIN_SETTLE) begin : g_bad_settle
        $error("sar_adc_ctrl: SETTLE_CYCLES must be at least SAR_MIN_SETTLE");
    end

    sar_state_e       state_q, state_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] idx_dec;
    cnt_t             cnt_q, cnt_d;
    logic             cmp_sync;

    sync_2ff u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cmp_in),
        .q     (cmp_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            code_q   <= '0;
            result_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        result_d = result_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        idx_dec  = idx_q - 1'b1;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d            = SETTLE;
                    code_d             = '0;
                    code_d[WIDTH-1]    = 1'b1;
                    idx_d              = IDX_W'(WIDTH - 1);
                    cnt_d              = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    code_d  = '0;
                end else if (cnt_q == '0) begin
                    state_d = DECIDE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DECIDE: begin
                if (abort) begin
                    state_d = IDLE;
                    code_d  = '0;
                end else begin
                    // Resolve the current trial bit, then either arm the next one or finish.
                    if (!cmp_sync) begin
                        code_d[idx_q] = 1'b0;
                    end
                    if (idx_q != '0) begin
                        code_d[idx_dec] = 1'b1;
                        idx_d           = idx_dec;
                        cnt_d           = CNT_W'(SETTLE_CYCLES - 1);
                        state_d         = SETTLE;
                    end else begin
                        result_d = code_d;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state_q == IDLE);
        dac_en    = (state_q == SETTLE) || (state_q == DECIDE);
        out_valid = (state_q == DONE);
        dac_code  = code_q;
        result    = result_q;
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: two configurations, an ideal comparator on each,
// a cycle-level conversion model and directed scenarios with literal expectations.
module tb_sar_adc_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  start_v;
    logic [1:0]  abort_v;
    logic [1:0]  ordy_v;
    logic [31:0] vin [2];

    logic        ready0, dac_en0, out_valid0, cmp0;
    logic [7:0]  dac0, result0;
    logic        ready1, dac_en1, out_valid1, cmp1;
    logic [9:0]  dac1, result1;

    int checks = 0;
    int errors = 0;

    // Model state: busy, valid, edges since acceptance, expected code/result.
    logic        mb [2];
    logic        mv [2];
    int          mt [2];
    logic [31:0] mcode [2];
    logic [31:0] mres [2];

    logic [7:0]  trial [8];
    logic [7:0]  exp_trial [8];

    assign cmp0 = (vin[0] >= 32'(dac0));
    assign cmp1 = (vin[1] >= 32'(dac1));

    sar_adc_ctrl #(.WIDTH(8), .SETTLE_CYCLES(4)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_v[0]),
        .abort     (abort_v[0]),
        .ready     (ready0),
        .dac_code  (dac0),
        .dac_en    (dac_en0),
        .cmp_in    (cmp0),
        .out_valid (out_valid0),
        .out_ready (ordy_v[0]),
        .result    (result0)
    );

    sar_adc_ctrl #(.WIDTH(10), .SETTLE_CYCLES(2)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_v[1]),
        .abort     (abort_v[1]),
        .ready     (ready1),
        .dac_code  (dac1),
        .dac_en    (dac_en1),
        .cmp_in    (cmp1),
        .out_valid (out_valid1),
        .out_ready (ordy_v[1]),
        .result    (result1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Code on the DAC t edges after acceptance: bits above the trial bit already
    // equal vin (ideal comparator), the trial bit is set, lower bits clear.
    function automatic logic [31:0] trial_code(input logic [31:0] v, input int t,
                                               input int w, input int s);
        int k;
        logic [31:0] hi_mask;
        k = w - 1 - t / (s + 1);
        hi_mask = ~((32'd1 << (k + 1)) - 32'd1);
        return (v & hi_mask) | (32'd1 << k);
    endfunction

    task automatic mstep(input int i, input int w, input int s);
        if (mv[i]) begin
            if (ordy_v[i]) mv[i] = 1'b0;
        end else if (mb[i]) begin
            if (abort_v[i]) begin
                mb[i]    = 1'b0;
                mcode[i] = '0;
            end else begin
                mt[i]++;
                if (mt[i] == w * (s + 1)) begin
                    mb[i]    = 1'b0;
                    mv[i]    = 1'b1;
                    mres[i]  = vin[i];
                    mcode[i] = vin[i];
                end else begin
                    mcode[i] = trial_code(vin[i], mt[i], w, s);
                end
            end
        end else if (start_v[i] && !abort_v[i]) begin
            mb[i]    = 1'b1;
            mt[i]    = 0;
            mcode[i] = 32'd1 << (w - 1);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mb[i] = 1'b0; mv[i] = 1'b0; mt[i] = 0;
                mcode[i] = '0; mres[i] = '0;
            end
        end else begin
            mstep(0, 8, 4);
            mstep(1, 10, 2);
        end
    end

    always @(negedge clk) begin
        chk("ready0",     32'(ready0),     32'(!mb[0] && !mv[0]));
        chk("dac_en0",    32'(dac_en0),    32'(mb[0]));
        chk("out_valid0", 32'(out_valid0), 32'(mv[0]));
        chk("dac_code0",  32'(dac0),       mcode[0]);
        chk("result0",    32'(result0),    mres[0]);
        chk("ready1",     32'(ready1),     32'(!mb[1] && !mv[1]));
        chk("dac_en1",    32'(dac_en1),    32'(mb[1]));
        chk("out_valid1", 32'(out_valid1), 32'(mv[1]));
        chk("dac_code1",  32'(dac1),       mcode[1]);
        chk("result1",    32'(result1),    mres[1]);
    end

    // Start a conversion on instance 0; optionally pulse start again at edge sp.
    task automatic run0(input logic [31:0] v, input int sp, output int lat);
        vin[0] = v;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        lat = 0;
        while (!out_valid0 && lat < 100) begin
            if (lat % 5 == 0 && lat < 40) trial[lat / 5] = dac0;
            start_v[0] = (lat == sp);
            @(negedge clk);
            lat++;
        end
        start_v[0] = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        rst_n   = 1'b0;
        start_v = '0;
        abort_v = '0;
        ordy_v  = 2'b11;
        vin[0]  = '0;
        vin[1]  = '0;
        exp_trial = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(ready0), 32'd1);
        chk("reset_dac", 32'(dac0), 32'd0);
        chk("reset_valid", 32'(out_valid0), 32'd0);
        chk("reset_result", 32'(result0), 32'd0);

        run0(32'hA5, -1, lat);
        chk("lat_A5", 32'(lat), 32'd40);
        chk("res_A5", 32'(result0), 32'hA5);
        for (int i = 0; i < 8; i++) chk("trial_A5", 32'(trial[i]), 32'(exp_trial[i]));
        @(negedge clk);
        chk("ready_after_A5", 32'(ready0), 32'd1);
        chk("dac_retained", 32'(dac0), 32'hA5);

        run0(32'h00, -1, lat);
        chk("res_00", 32'(result0), 32'h00);
        chk("dac_en_done", 32'(dac_en0), 32'd0);
        @(negedge clk);
        run0(32'hFF, -1, lat);
        chk("res_FF", 32'(result0), 32'hFF);
        @(negedge clk);
        chk("dac_en_idle", 32'(dac_en0), 32'd0);

        ordy_v[0] = 1'b0;
        run0(32'h5A, -1, lat);
        for (int i = 0; i < 10; i++) begin
            start_v[0] = (i == 3);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid0), 32'd1);
            chk("hold_result", 32'(result0), 32'h5A);
        end
        start_v[0] = 1'b0;
        ordy_v[0] = 1'b1;
        @(negedge clk);
        chk("accept_ready", 32'(ready0), 32'd1);
        @(negedge clk);
        chk("no_queued_start", 32'(dac_en0), 32'd0);

        run0(32'h71, 12, lat);
        chk("lat_71", 32'(lat), 32'd40);
        chk("res_71", 32'(result0), 32'h71);
        @(negedge clk);

        vin[0] = 32'h33;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (15) @(negedge clk);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        chk("abort_ready", 32'(ready0), 32'd1);
        chk("abort_dac", 32'(dac0), 32'd0);
        seen = 0;
        repeat (45) begin
            @(negedge clk);
            if (out_valid0) seen++;
        end
        chk("abort_no_result", 32'(seen), 32'd0);

        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        chk("abort_wins_ready", 32'(ready0), 32'd1);
        chk("abort_wins_en", 32'(dac_en0), 32'd0);

        vin[0] = 32'h3C;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (7) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(ready0), 32'd1);
        chk("rst_dac_en", 32'(dac_en0), 32'd0);
        chk("rst_dac", 32'(dac0), 32'd0);
        chk("rst_valid", 32'(out_valid0), 32'd0);
        chk("rst_result", 32'(result0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run0(32'h3C, -1, lat);
        chk("lat_3C", 32'(lat), 32'd40);
        chk("res_3C", 32'(result0), 32'h3C);
        @(negedge clk);

        vin[1] = 32'h2AA;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("lat_w10", 32'(lat), 32'd30);
        chk("res_w10", 32'(result1), 32'h2AA);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Successive-approximation controller that turns the averaging EPOT DAC tile into an ADC. It drives the DAC code into the tile and samples the analog comparator on the tile's buffered output. Over WIDTH trial cycles it resolves the input voltage to a digital word. It sits in the digital fabric beside the analog tile and hands each result to the consumer over a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 8, resolution in bits; also the DAC code width.
- SETTLE_CYCLES, 4, clocks allowed for DAC/buffer settling per trial bit; must be ≥ 2 (covers comparator synchronizer latency); elaboration error otherwise.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset: asynchronous assert, active-low.
- start  in  1  request a conversion; accepted only when ready=1.
- abort  in  1  synchronous cancel of an in-flight conversion.
- ready  out  1  high in IDLE only.
- dac_code  out  WIDTH  code driven to the EPOT DAC tile.
- dac_en  out  1  high while a conversion is trialing (SETTLE/DECIDE).
- cmp_in  in  1  raw comparator output, 1 = Vin ≥ Vdac; asynchronous to clk.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  converted code; valid while out_valid=1.

## Operation
- Reset values: ready=1, dac_en=0, dac_code=0, out_valid=0, result=0, state=IDLE, synchronizer flops=0.
- States: IDLE, SETTLE, DECIDE, DONE.
- IDLE: if start=1 and abort=0 at an edge, go to SETTLE. Load dac_code = 1<<(WIDTH-1), bit index = WIDTH-1, settle counter = SETTLE_CYCLES-1.
- SETTLE: decrement the counter each cycle. When it reaches 0, go to DECIDE.
- DECIDE (one cycle): sample the synchronized comparator.
  - If 0, clear dac_code[idx]; if 1, keep it.
  - If idx>0: set dac_code[idx-1], decrement idx, reload the counter, and return to SETTLE.
  - If idx=0: go to DONE; result ← final code; out_valid=1.
- DONE: hold result and dac_code. When out_valid & out_ready, go to IDLE; out_valid drops the same edge.
- dac_code retains the last result in IDLE until the next start.
- start while not IDLE: ignored. start is not queued.
- abort in SETTLE/DECIDE: go to IDLE next edge; dac_code=0; no result issued. abort and start in the same IDLE cycle: abort wins, no conversion. abort in DONE: ignored (result still delivered).
- Asynchronous reset at any point, including mid-conversion or DONE, forces all reset values immediately.
- Arithmetic: unsigned code; no overflow possible (bit-set/clear only).

## Timing
- Per bit: SETTLE_CYCLES + 1 cycles.
- Latency from the edge accepting start to out_valid high: WIDTH·(SETTLE_CYCLES+1) cycles (40 at defaults).
- The comparator is sampled in DECIDE via a 2-flop synchronizer. The sampled value reflects cmp_in from ≥ SETTLE_CYCLES-2 cycles after the trial code was applied.
- With out_ready held high: DONE lasts 1 cycle, ready returns the next cycle, and back-to-back conversions restart with one IDLE cycle between.
- out_valid, once asserted, stays high with result stable until accepted.

## Structure
- Shared package sar_pkg holds:
  - the state enum (IDLE, SETTLE, DECIDE, DONE);
  - SAR_MIN_SETTLE = 2;
  - a typedef for the settle counter width, $clog2(SETTLE_CYCLES).
- One sub-module: sync_2ff (2-flop synchronizer, reset to 0 asynchronously), instantiated on cmp_in.
- The FSM, counter and SAR register live in sar_adc_ctrl.

## Test plan
- Comparator model cmp_in = (vin ≥ dac_code), vin=0xA5, start pulse → out_valid exactly 40 cycles later, result=0xA5, trial codes 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5.
- vin=0x00 and vin=0xFF → results 0x00 and 0xFF; dac_en low in IDLE/DONE.
- out_ready held low for 10 cycles at DONE → out_valid and result held stable; a start pulse during DONE is ignored; accept → ready=1 next cycle.
- start pulsed at cycle 12 of a conversion → ignored, result unaffected. abort at cycle 15 → IDLE next edge, dac_code=0, no out_valid. abort+start together in IDLE → no conversion.
- rst_n asserted mid-SETTLE → all outputs at reset values immediately. After deassert, a new conversion of vin=0x3C → 0x3C.
- SETTLE_CYCLES=2, WIDTH=10, vin=0x2AA → result 0x2AA after 30 cycles.
